// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU with iterative multiply/divide.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001,
    OP_MFHI  = 4'b1010,
    OP_MFLO  = 4'b1011,
    OP_SLTU  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (MSB-first shift-add) and restoring divide, one bit per cycle.
// The accumulator holds {product} for MUL and {remainder, quotient} for DIV.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic             divByZero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_div;
  logic [2*WIDTH-1:0] w_acc;
  logic [CNT_W-1:0]   w_idx;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-2:0]   w_q;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_next;

  // One iteration step; on start the step runs straight from the incoming operands.
  always_comb begin
    w_a        = start_i ? a_i   : r_a;
    w_b        = start_i ? b_i   : r_b;
    w_div      = start_i ? div_i : r_div;
    w_acc      = start_i ? '0    : r_acc;
    w_idx      = start_i ? CNT_W'(WIDTH - 1) : r_cnt;
    w_mul_next = {w_acc[2*WIDTH-2:0], 1'b0}
               + (w_b[w_idx] ? {{WIDTH{1'b0}}, w_a} : '0);
    w_rem      = w_acc[2*WIDTH-1:WIDTH];
    w_q        = w_acc[WIDTH-2:0];
    w_shift    = {w_rem, w_a[w_idx]};
    w_ge       = (w_shift >= {1'b0, w_b});
    w_diff     = w_shift[WIDTH-1:0] - w_b;
    w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
    w_div_next = {w_rem_next, w_q, w_ge};
    w_next     = w_div ? w_div_next : w_mul_next;
  end

  // Operand latch, accumulator and down-counter.
  // Bit WIDTH-1 is processed in the accept cycle, so the stored counter starts at WIDTH-2
  // and reaching zero marks the final step, giving completion WIDTH cycles after accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (start_i) begin
      r_a   <= a_i;
      r_b   <= b_i;
      r_div <= div_i;
      r_acc <= w_next;
      r_cnt <= CNT_W'(WIDTH - 2);
    end else if (step_i) begin
      r_acc <= w_next;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign done_o      = step_i & (r_cnt == '0);
  assign divByZero_o = done_o & r_div & (r_b == '0);
  assign hi_o        = w_next[2*WIDTH-1:WIDTH];
  assign lo_o        = w_next[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle ops plus iterative MULTU/DIVU with HI/LO.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] srcA_i,
  input  logic [WIDTH-1:0] srcB_i,
  input  logic [3:0]       aluControl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             divByZero_o
);

  alu_state_t       r_state;
  alu_state_t       w_next_state;
  alu_op_t          w_op;
  logic             w_accept;
  logic             w_start;
  logic             w_div;
  logic             w_eq;
  logic [WIDTH-1:0] w_alu;
  logic             w_done;
  logic             w_dbz;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_zero_pend;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  assign w_op = alu_op_t'(aluControl_i);
  assign w_eq = (srcA_i == srcB_i);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state, handshake and iteration start.
  always_comb begin
    w_next_state = r_state;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_div        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o  = 1'b1;
        w_accept = valid_i;
        if (valid_i && (w_op == OP_MULTU)) begin
          w_start      = 1'b1;
          w_next_state = ST_MUL;
        end else if (valid_i && (w_op == OP_DIVU)) begin
          w_start      = 1'b1;
          w_div        = 1'b1;
          w_next_state = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        busy_o = 1'b1;
        if (w_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Single-cycle operation results.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = srcA_i + srcB_i;
      OP_SUB:  w_alu = srcA_i - srcB_i;
      OP_AND:  w_alu = srcA_i & srcB_i;
      OP_OR:   w_alu = srcA_i | srcB_i;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(srcA_i) < $signed(srcB_i))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (srcA_i < srcB_i)};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (w_start),
    .step_i      (busy_o),
    .div_i       (w_div),
    .a_i         (srcA_i),
    .b_i         (srcB_i),
    .done_o      (w_done),
    .divByZero_o (w_dbz),
    .hi_o        (w_hi),
    .lo_o        (w_lo)
  );

  // Result, flag and HI/LO registers; completion and single-cycle accept never coincide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_zero_pend <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
      if (w_accept && !w_start) begin
        r_result <= w_alu;
        r_zero   <= w_eq;
        r_valid  <= 1'b1;
      end
      if (w_start) r_zero_pend <= w_eq;
      if (w_done) begin
        r_hi     <= w_hi;
        r_lo     <= w_lo;
        r_result <= w_lo;
        r_zero   <= r_zero_pend;
        r_valid  <= 1'b1;
        r_dbz    <= w_dbz;
      end
    end
  end

  assign valid_o     = r_valid;
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign divByZero_o = r_dbz;

endmodule
